// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: operation encoding and default sizing.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ACC  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline register slice carrying a valid bit and the {sum, carry, ovf} result.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] sum_d,
  input  logic             carry_d,
  input  logic             ovf_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             ovf_q
);

  // Load the slice whenever the pipeline advances, otherwise hold it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ADD/SUB/accumulate unit with valid/ready handshakes and a global stall.
// All arithmetic happens before the first register; later slices only delay.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic             advance;
  logic             accept;
  op_e              op_sel;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_op;
  logic [WIDTH-1:0] opx;
  logic [WIDTH-1:0] opy;
  logic             c0;
  logic [WIDTH:0]   res;
  logic             res_carry;
  logic             res_ovf;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             ovf_q   [STAGES];

  // The whole pipe moves together; a held output blocks every slice and the input.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign op_sel   = op_e'(op);
  assign acc_op   = acc_clr ? '0 : acc;

  // Select operands so every operation reduces to one WIDTH+1 bit addition.
  always_comb begin
    opx = a;
    opy = b;
    c0  = cin;
    case (op_sel)
      OP_SUB: begin
        opy = ~b;
        c0  = 1'b1;
      end
      OP_ACC: begin
        opx = acc_op;
        opy = a;
        c0  = 1'b0;
      end
      default: begin
        opx = a;
        opy = b;
        c0  = cin;
      end
    endcase
    res       = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, c0};
    res_carry = (op_sel == OP_SUB) ? ~res[WIDTH] : res[WIDTH];
    res_ovf   = (opx[WIDTH-1] == opy[WIDTH-1]) && (res[WIDTH-1] != opx[WIDTH-1]);
  end

  // Accumulator updates at acceptance so the very next ACC beat sees the new value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
    end else if (accept) begin
      if (op_sel == OP_ACC) begin
        acc <= res[WIDTH-1:0];
      end else if (acc_clr) begin
        acc <= '0;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      pipe_adder_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .en      (advance),
        .valid_d (accept),
        .sum_d   (res[WIDTH-1:0]),
        .carry_d (res_carry),
        .ovf_d   (res_ovf),
        .valid_q (valid_q[g]),
        .sum_q   (sum_q[g]),
        .carry_q (carry_q[g]),
        .ovf_q   (ovf_q[g])
      );
    end else begin : g_delay
      pipe_adder_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .en      (advance),
        .valid_d (valid_q[g-1]),
        .sum_d   (sum_q[g-1]),
        .carry_d (carry_q[g-1]),
        .ovf_d   (ovf_q[g-1]),
        .valid_q (valid_q[g]),
        .sum_q   (sum_q[g]),
        .carry_q (carry_q[g]),
        .ovf_q   (ovf_q[g])
      );
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed checks on an 8-bit/2-stage copy, randomized
// traffic on a 16-bit/4-stage copy, both scored against an arithmetic model.
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;

  // 8-bit, 2-stage instance
  logic       rstn8 = 1'b0, in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, acc_clr8 = 1'b0;
  logic [1:0] op8 = 2'd0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       out_valid8, out_ready8 = 1'b1, carry8, ovf8;

  // 16-bit, 4-stage instance
  logic        rstn16 = 1'b0, in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, acc_clr16 = 1'b0;
  logic [1:0]  op16 = 2'd0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        out_valid16, out_ready16 = 1'b1, carry16, ovf16;

  pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rstn(rstn8), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .cin(cin8), .acc_clr(acc_clr8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .carry(carry8), .ovf(ovf8)
  );

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rstn(rstn16), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .cin(cin16), .acc_clr(acc_clr16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .carry(carry16), .ovf(ovf16)
  );

  typedef struct {
    longint sum;
    bit     carry;
    bit     ovf;
    int     acc_cycle;
    int     snap;
    bit     seen;
  } exp_t;

  exp_t   expq [2][$];
  longint macc [2];
  int     stalls [2];
  bit     prev_rstn [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Plain integer arithmetic: unsigned result modulo 2^w, signed range test for overflow.
  function automatic void ref_calc(input int w, input logic [1:0] o, input longint av,
                                   input longint bv, input bit c, input longint accop,
                                   output longint s, output bit cy, output bit ov);
    longint m  = longint'(1) << w;
    longint hi = longint'(1) << (w - 1);
    longint full;
    longint sr;
    case (o)
      2'd1: begin
        s  = (av - bv + m) % m;
        cy = (av < bv);
        sr = sx(av, w) - sx(bv, w);
      end
      2'd2: begin
        full = accop + av;
        s    = full % m;
        cy   = (full >= m);
        sr   = sx(accop, w) + sx(av, w);
      end
      default: begin
        full = av + bv + longint'(c);
        s    = full % m;
        cy   = (full >= m);
        sr   = sx(av, w) + sx(bv, w) + longint'(c);
      end
    endcase
    ov = (sr < -hi) || (sr >= hi);
  endfunction

  task automatic checkOutput(input int i, input int w, input int st, input logic rs,
                             input logic vin, input logic rdy, input logic [1:0] o,
                             input logic [63:0] av, input logic [63:0] bv, input logic c,
                             input logic clr, input logic vout, input logic ordy,
                             input logic [63:0] sv, input logic cv, input logic ov);
    exp_t   e;
    longint s;
    bit     ecy;
    bit     eov;
    if (!rs) begin
      if (!prev_rstn[i]) check($sformatf("w%0d_valid_in_reset", w), 64'(vout), 64'(0));
      expq[i].delete();
      macc[i]      = 0;
      prev_rstn[i] = 1'b0;
      return;
    end
    prev_rstn[i] = 1'b1;
    check($sformatf("w%0d_in_ready", w), 64'(rdy), 64'(!vout || ordy));
    if (vout) begin
      if (expq[i].size() == 0) begin
        check($sformatf("w%0d_unexpected_beat", w), 64'(vout), 64'(0));
      end else begin
        e = expq[i][0];
        if (!e.seen) begin
          check($sformatf("w%0d_latency", w), 64'(cyc - e.acc_cycle),
                64'(st + (stalls[i] - e.snap)));
          expq[i][0].seen = 1'b1;
        end
        check($sformatf("w%0d_sum", w), sv, 64'(e.sum));
        check($sformatf("w%0d_carry", w), 64'(cv), 64'(e.carry));
        check($sformatf("w%0d_ovf", w), 64'(ov), 64'(e.ovf));
        if (ordy) void'(expq[i].pop_front());
      end
    end
    if (!rdy) stalls[i]++;
    if (vin && rdy) begin
      ref_calc(w, o, longint'(av), longint'(bv), c, clr ? 64'd0 : macc[i], s, ecy, eov);
      e.sum       = s;
      e.carry     = ecy;
      e.ovf       = eov;
      e.acc_cycle = cyc;
      e.snap      = stalls[i];
      e.seen      = 1'b0;
      expq[i].push_back(e);
      if (o == 2'd2) macc[i] = s;
      else if (clr) macc[i] = 0;
    end
  endtask

  // Score both instances once per cycle, away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    checkOutput(0, 8, 2, rstn8, in_valid8, in_ready8, op8, 64'(a8), 64'(b8), cin8,
                acc_clr8, out_valid8, out_ready8, 64'(sum8), carry8, ovf8);
    checkOutput(1, 16, 4, rstn16, in_valid16, in_ready16, op16, 64'(a16), 64'(b16), cin16,
                acc_clr16, out_valid16, out_ready16, 64'(sum16), carry16, ovf16);
  end

  // Present one beat to the 8-bit copy and hold it until it is taken.
  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                               input logic c, input logic clr);
    bit took = 1'b0;
    in_valid8 = 1'b1;
    op8       = o;
    a8        = av;
    b8        = bv;
    cin8      = c;
    acc_clr8  = clr;
    for (int n = 0; n < 20 && !took; n++) begin
      @(negedge clk);
      took = in_ready8;
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    acc_clr8  = 1'b0;
    if (!took) check("accept_timeout8", 64'(took), 64'(1));
  endtask

  task automatic checkOut8(input string name, input bit v, input logic [7:0] s,
                           input bit c, input bit o);
    check({name, "_valid"}, 64'(out_valid8), 64'(v));
    if (v) begin
      check({name, "_sum"}, 64'(sum8), 64'(s));
      check({name, "_carry"}, 64'(carry8), 64'(c));
      check({name, "_ovf"}, 64'(ovf8), 64'(o));
    end
  endtask

  task automatic drain8;
    for (int n = 0; n < 30 && expq[0].size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain8", 64'(expq[0].size()), 64'(0));
  endtask

  task automatic runDirected;
    out_ready8 = 1'b1;
    rstn8      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid8", 64'(out_valid8), 64'(0));
    check("rst_sum8", 64'(sum8), 64'(0));
    check("rst_carry8", 64'(carry8), 64'(0));
    check("rst_ovf8", 64'(ovf8), 64'(0));
    check("rst_in_ready8", 64'(in_ready8), 64'(1));
    rstn8 = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(2'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    checkOut8("add_early", 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOut8("add_ff_01", 1'b1, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    applyStimulus(2'd1, 8'h05, 8'h07, 1'b1, 1'b0);
    applyStimulus(2'd1, 8'h80, 8'h01, 1'b0, 1'b0);
    checkOut8("sub_05_07", 1'b1, 8'hFE, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOut8("sub_80_01", 1'b1, 8'h7F, 1'b0, 1'b1);

    applyStimulus(2'd2, 8'h10, 8'h55, 1'b1, 1'b1);
    applyStimulus(2'd2, 8'h20, 8'h00, 1'b0, 1'b0);
    checkOut8("acc_10", 1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(2'd2, 8'h30, 8'h00, 1'b0, 1'b0);
    checkOut8("acc_30", 1'b1, 8'h30, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOut8("acc_60", 1'b1, 8'h60, 1'b0, 1'b0);
    drain8();

    fork
      begin
        for (int k = 0; k < 8; k++) applyStimulus(2'd0, 8'(k * 17), 8'(k + 3), 1'(k), 1'b0);
      end
      begin
        out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready8", 64'(in_ready8), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        out_ready8 = 1'b1;
      end
    join
    drain8();

    out_ready8 = 1'b0;
    applyStimulus(2'd0, 8'h11, 8'h22, 1'b0, 1'b0);
    applyStimulus(2'd0, 8'h33, 8'h44, 1'b0, 1'b0);
    rstn8 = 1'b0;
    @(posedge clk);
    #1;
    check("flush_valid8", 64'(out_valid8), 64'(0));
    check("flush_sum8", 64'(sum8), 64'(0));
    check("flush_in_ready8", 64'(in_ready8), 64'(1));
    rstn8      = 1'b1;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid8", 64'(out_valid8), 64'(0));
    applyStimulus(2'd2, 8'h01, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOut8("acc_after_rst", 1'b1, 8'h01, 1'b0, 1'b0);
    drain8();
  endtask

  task automatic runRandom;
    rstn16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn16 = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      in_valid16  = ($urandom_range(0, 3) != 0);
      op16        = 2'($urandom_range(0, 3));
      a16         = 16'($urandom);
      b16         = 16'($urandom);
      cin16       = 1'($urandom);
      acc_clr16   = ($urandom_range(0, 7) == 0);
      out_ready16 = ($urandom_range(0, 9) < 7);
      rstn16      = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      #1;
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    rstn16      = 1'b1;
    for (int n = 0; n < 30 && expq[1].size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain16", 64'(expq[1].size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      macc[i]      = 0;
      stalls[i]    = 0;
      prev_rstn[i] = 1'b0;
    end
    fork
      runDirected();
      runRandom();
    join
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
